// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
// The pipeline is the master; the unit is the slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] Op1;
  logic [WIDTH-1:0] Op2;
  logic [2:0]       MDOp;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Op1, Op2, MDOp, start,
    input  busy, HI, LO
  );

  modport slave (
    input  Op1, Op2, MDOp, start,
    output busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Optional feature macro: MDU_MADD_EN (adds madd/maddu accumulate ops 6/7).
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  count_r;
  logic [2:0]        op_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  hi_r;
  logic [WIDTH-1:0]  lo_r;
  logic              busy_r;

  logic [2*WIDTH-1:0] res_s;
  logic               wr_s;

  function automatic logic [2*WIDTH-1:0] mul_signed(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ea;
    logic signed [2*WIDTH-1:0] eb;
    ea = $signed({{WIDTH{a[WIDTH-1]}}, a});
    eb = $signed({{WIDTH{b[WIDTH-1]}}, b});
    return ea * eb;
  endfunction

  function automatic logic [2*WIDTH-1:0] mul_unsigned(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
    return {ZERO_W, a} * {ZERO_W, b};
  endfunction

  // Result packed as {remainder, quotient} so it lines up with {HI, LO}.
  function automatic logic [2*WIDTH-1:0] div_unsigned(input logic [WIDTH-1:0] n,
                                                       input logic [WIDTH-1:0] d);
    logic [2*WIDTH-1:0] r;
    if (d == ZERO_W) begin
      r = ZERO_2W;
    end else begin
      r = {n % d, n / d};
    end
    return r;
  endfunction

  // Works on magnitudes, so -2^(WIDTH-1) / -1 naturally yields LO=-2^(WIDTH-1), HI=0.
  function automatic logic [2*WIDTH-1:0] div_signed(input logic [WIDTH-1:0] n,
                                                     input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0]   mag_n;
    logic [WIDTH-1:0]   mag_d;
    logic [2*WIDTH-1:0] qr;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;
    if (n[WIDTH-1]) begin
      mag_n = ZERO_W - n;
    end else begin
      mag_n = n;
    end
    if (d[WIDTH-1]) begin
      mag_d = ZERO_W - d;
    end else begin
      mag_d = d;
    end
    qr = div_unsigned(mag_n, mag_d);
    q  = qr[WIDTH-1:0];
    r  = qr[2*WIDTH-1:WIDTH];
    if (n[WIDTH-1] ^ d[WIDTH-1]) begin
      q = ZERO_W - q;
    end else begin
      q = q;
    end
    if (n[WIDTH-1]) begin
      r = ZERO_W - r;
    end else begin
      r = r;
    end
    return {r, q};
  endfunction

  // Completion result from the latched op/operands; accumulate ops read live HI/LO.
  always_comb begin
    res_s = {hi_r, lo_r};
    wr_s  = 1'b0;
    case (op_r)
      OP_MULT: begin
        res_s = mul_signed(a_r, b_r);
        wr_s  = 1'b1;
      end
      OP_MULTU: begin
        res_s = mul_unsigned(a_r, b_r);
        wr_s  = 1'b1;
      end
      OP_DIV: begin
        if (b_r != ZERO_W) begin
          res_s = div_signed(a_r, b_r);
          wr_s  = 1'b1;
        end else begin
          res_s = {hi_r, lo_r};
          wr_s  = 1'b0;
        end
      end
      OP_DIVU: begin
        if (b_r != ZERO_W) begin
          res_s = div_unsigned(a_r, b_r);
          wr_s  = 1'b1;
        end else begin
          res_s = {hi_r, lo_r};
          wr_s  = 1'b0;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        res_s = {hi_r, lo_r} + mul_signed(a_r, b_r);
        wr_s  = 1'b1;
      end
      OP_MADDU: begin
        res_s = {hi_r, lo_r} + mul_unsigned(a_r, b_r);
        wr_s  = 1'b1;
      end
`endif
      default: begin
        res_s = {hi_r, lo_r};
        wr_s  = 1'b0;
      end
    endcase
  end

  // Issue/countdown FSM; owns HI/LO and busy. Start is only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= CNT_ZERO;
      op_r    <= 3'd0;
      a_r     <= ZERO_W;
      b_r     <= ZERO_W;
      hi_r    <= ZERO_W;
      lo_r    <= ZERO_W;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            case (bus.MDOp)
`ifdef MDU_MADD_EN
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
`else
              OP_MULT, OP_MULTU: begin
`endif
                op_r    <= bus.MDOp;
                a_r     <= bus.Op1;
                b_r     <= bus.Op2;
                count_r <= MULT_LOAD;
                state_r <= RUN;
                busy_r  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                op_r    <= bus.MDOp;
                a_r     <= bus.Op1;
                b_r     <= bus.Op2;
                count_r <= DIV_LOAD;
                state_r <= RUN;
                busy_r  <= 1'b1;
              end
              OP_MTHI: hi_r <= bus.Op1;
              OP_MTLO: lo_r <= bus.Op1;
              default: state_r <= IDLE;
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (count_r == CNT_ONE) begin
            if (wr_s) begin
              hi_r <= res_s[2*WIDTH-1:WIDTH];
              lo_r <= res_s[WIDTH-1:0];
            end else begin
              hi_r <= hi_r;
            end
            count_r <= CNT_ZERO;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            count_r <= count_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= CNT_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;

endmodule
